// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and stall request.
// Define ID_EX_WB_BYPASS_EN to forward the write-back port into ex_a/ex_b.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       ReadData1,
  input  logic [31:0]       ReadData2,
  input  logic              wb_we,
  input  logic [4:0]        wb_waddr,
  input  logic [31:0]       wb_wdata,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic        ex_is_load;
  logic        rs_hit;
  logic        rt_hit;
  logic        load_use;
  logic        bubble;
  logic [31:0] op_a;
  logic [31:0] op_b;

  assign ex_is_load = ex_valid & ex_ctrl[1] & (ex_rt != 5'd0);
  assign rs_hit     = (ex_rt == id_rs);
  assign rt_hit     = id_uses_rt & (ex_rt == id_rt);
  assign load_use   = ex_is_load & id_valid & (rs_hit | rt_hit);
  assign stall_out  = (load_use & ~flush) | ex_hold;
  assign bubble     = flush | load_use;

`ifdef ID_EX_WB_BYPASS_EN
  // Same-edge RF write is not yet visible in ReadData, so forward it.
  logic byp_a;
  logic byp_b;

  assign byp_a = wb_we & (wb_waddr == id_rs) & (id_rs != 5'd0);
  assign byp_b = wb_we & (wb_waddr == id_rt) & (id_rt != 5'd0);
  assign op_a  = byp_a ? wb_wdata : ReadData1;
  assign op_b  = byp_b ? wb_wdata : ReadData2;
`else
  logic unused_wb;

  assign unused_wb = ^{wb_we, wb_waddr, wb_wdata};
  assign op_a      = ReadData1;
  assign op_b      = ReadData2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_imm    <= '0;
      ex_ctrl   <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      stall_cnt <= '0;
    end else if (!ex_hold) begin
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_rd  <= id_rd;
      ex_imm <= id_imm;
      ex_a   <= op_a;
      ex_b   <= op_b;
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : '0;
      end
      if (load_use && !flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage.
// A second instance with a 2-bit counter exercises saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] id_imm;
  logic [7:0]  id_ctrl;
  logic [31:0] rd1, rd2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush, ex_hold;

  logic        stall_out, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_imm, ex_a, ex_b;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_cnt;

  logic        s_stall, s_valid;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_imm, s_a, s_b;
  logic [7:0]  s_ctrl;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        bub;
    logic        v;
    logic [7:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, a, b;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  logic [15:0] cnt_exp = 16'd0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .ReadData1(rd1), .ReadData2(rd2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush(flush), .ex_hold(ex_hold), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
    .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CTRL_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .ReadData1(rd1), .ReadData2(rd2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush(flush), .ex_hold(ex_hold), .stall_out(s_stall),
    .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_imm(s_imm), .ex_ctrl(s_ctrl), .ex_a(s_a), .ex_b(s_b),
    .stall_cnt(s_cnt)
  );

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [4:0] rs, logic [4:0] rt,
                       logic [4:0] rd, logic ur, logic [31:0] imm,
                       logic [7:0] ctrl, logic [31:0] a,
                       logic [31:0] b);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = ur; id_imm = imm; id_ctrl = ctrl;
    rd1 = a; rd2 = b;
  endtask

  task automatic push_ok(logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.bub = 1'b0; e.v = id_valid;
    e.ctrl = id_valid ? id_ctrl : 8'h00;
    e.rs = id_rs; e.rt = id_rt; e.rd = id_rd; e.imm = id_imm;
    e.a = a; e.b = b; e.cnt = cnt_exp;
    sb.push_back(e);
  endtask

  task automatic push_bub(logic counted);
    exp_t e;
    if (counted) cnt_exp++;
    e = '{bub: 1'b1, v: 1'b0, ctrl: 8'h00, rs: 5'd0, rt: 5'd0,
          rd: 5'd0, imm: 32'd0, a: 32'd0, b: 32'd0, cnt: cnt_exp};
    sb.push_back(e);
  endtask

  task automatic stall_is(string tag, logic exp);
    #1;
    chk({tag, "_stall"}, 128'(stall_out), 128'(exp));
    chk({tag, "_sstall"}, 128'(s_stall), 128'(exp));
  endtask

  task automatic tick(string tag);
    exp_t e;
    logic [15:0] sc;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s_sb: got empty queue want entry", tag);
      return;
    end
    checks--;
    e = sb.pop_front();
    sc = (e.cnt > 16'd3) ? 16'd3 : e.cnt;
    chk({tag, "_valid"}, 128'({ex_valid, s_valid}), 128'({e.v, e.v}));
    chk({tag, "_ctrl"}, 128'({ex_ctrl, s_ctrl}), 128'({e.ctrl, e.ctrl}));
    chk({tag, "_cnt"}, 128'(stall_cnt), 128'(e.cnt));
    chk({tag, "_scnt"}, 128'(s_cnt), 128'(sc));
    if (!e.bub) begin
      chk({tag, "_fields"}, 128'({ex_rs, ex_rt, ex_rd, ex_imm}),
          128'({e.rs, e.rt, e.rd, e.imm}));
      chk({tag, "_ops"}, 128'({ex_a, ex_b}), 128'({e.a, e.b}));
      chk({tag, "_sfields"}, 128'({s_rs, s_rt, s_rd, s_imm, s_a, s_b}),
          128'({e.rs, e.rt, e.rd, e.imm, e.a, e.b}));
      last = e;
    end
  endtask

  // One load followed by a dependent consumer: stall, bubble, advance.
  task automatic load_use_pair(string tag);
    drive(1, 5'd1, 5'd8, 5'd0, 0, 32'h4, 8'h03, 32'h100, 32'h0);
    push_ok(32'h100, 32'h0);
    tick({tag, "_ld"});
    drive(1, 5'd8, 5'd2, 5'd9, 1, 32'h7, 8'h01, 32'hAA, 32'hBB);
    stall_is({tag, "_lu"}, 1'b1);
    push_bub(1'b1);
    tick({tag, "_bub"});
    stall_is({tag, "_go"}, 1'b0);
    push_ok(32'hAA, 32'hBB);
    tick({tag, "_use"});
  endtask

  initial begin
    logic bp;
`ifdef ID_EX_WB_BYPASS_EN
    bp = 1'b1;
`else
    bp = 1'b0;
`endif
    rst = 1'b1;
    drive($urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
          $urandom, 8'($urandom), $urandom, $urandom);
    wb_we = $urandom; wb_waddr = 5'($urandom); wb_wdata = $urandom;
    flush = $urandom; ex_hold = $urandom;
    @(posedge clk);
    push_bub(1'b0);
    sb[0].bub = 1'b0;
    tick("reset");
    ex_hold = 1'b0;
    stall_is("reset", 1'b0);
    rst = 1'b0;
    flush = 1'b0; wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;

    drive(1, 5'd3, 5'd4, 5'd6, 1, 32'h10, 8'h05, 32'h1234, 32'h9);
    stall_is("pass", 1'b0);
    push_ok(32'h1234, 32'h9);
    tick("pass");

    load_use_pair("lu1");

    drive(1, 5'd3, 5'd0, 5'd0, 0, 32'h4, 8'h03, 32'h1, 32'h2);
    push_ok(32'h1, 32'h2);
    tick("ld_r0");
    drive(1, 5'd0, 5'd0, 5'd7, 1, 32'h0, 8'h01, 32'h3, 32'h4);
    stall_is("rt_zero", 1'b0);
    push_ok(32'h3, 32'h4);
    tick("rt_zero");

    drive(1, 5'd1, 5'd8, 5'd0, 0, 32'h4, 8'h03, 32'h5, 32'h6);
    push_ok(32'h5, 32'h6);
    tick("ld_r8");
    drive(1, 5'd3, 5'd8, 5'd7, 0, 32'h0, 8'h01, 32'h7, 32'h8);
    stall_is("no_rt_use", 1'b0);
    push_ok(32'h7, 32'h8);
    tick("no_rt_use");

    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEADBEEF;
    drive(1, 5'd5, 5'd5, 5'd5, 1, 32'h0, 8'h01, 32'h11, 32'h0);
    push_ok(bp ? 32'hDEADBEEF : 32'h11, bp ? 32'hDEADBEEF : 32'h0);
    tick("byp_hit");
    wb_waddr = 5'd0;
    drive(1, 5'd0, 5'd0, 5'd5, 1, 32'h0, 8'h01, 32'h11, 32'h0);
    push_ok(32'h11, 32'h0);
    tick("byp_r0");
    wb_we = 1'b0; wb_waddr = 5'd5;
    drive(1, 5'd5, 5'd5, 5'd5, 1, 32'h0, 8'h01, 32'h22, 32'h33);
    push_ok(32'h22, 32'h33);
    tick("byp_off");
    wb_waddr = 5'd0; wb_wdata = 32'h0;

    drive(1, 5'd1, 5'd8, 5'd0, 0, 32'h4, 8'h03, 32'h100, 32'h0);
    push_ok(32'h100, 32'h0);
    tick("fl_ld");
    drive(1, 5'd8, 5'd2, 5'd9, 1, 32'h7, 8'h01, 32'hAA, 32'hBB);
    flush = 1'b1;
    stall_is("fl_lu", 1'b0);
    push_bub(1'b0);
    tick("fl_lu");
    flush = 1'b0;

    drive(1, 5'd12, 5'd13, 5'd14, 1, 32'hC0DE, 8'h81, 32'h55, 32'h66);
    push_ok(32'h55, 32'h66);
    tick("pre_hold");
    drive(1, 5'd1, 5'd2, 5'd3, 1, 32'h1, 8'h7F, 32'h77, 32'h88);
    flush = 1'b1; ex_hold = 1'b1;
    stall_is("hold_fl", 1'b1);
    sb.push_back(last);
    tick("hold_fl");
    flush = 1'b0;
    sb.push_back(last);
    tick("hold2");
    ex_hold = 1'b0;
    push_ok(32'h77, 32'h88);
    tick("release");

    for (int i = 0; i < 4; i++) load_use_pair("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
